// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: loadable instruction store plus a LOAD/RUN/HALT fetch engine
// that issues one registered word per cycle, honouring stall, redirect and self-loop halt.
module instr_fetch_unit #(
   parameter int DEPTH_WORDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        initialize,
   input  logic [31:0] instruction_initialize_data,
   input  logic [31:0] instruction_initialize_address,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        instr_valid,
   output logic        halted,
   output logic        init_error,
   output logic [1:0]  fsm_state
);

   localparam int AW = $clog2(DEPTH_WORDS);

   // Debug encoding on fsm_state: 0 = LOAD, 1 = RUN, 2 = HALT.
   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   mem [DEPTH_WORDS];
   logic [31:0]   pc_q;
   logic [AW-1:0] wr_idx, rd_idx;
   logic          wr_bad, self_loop;

   assign wr_idx = instruction_initialize_address[AW+1:2];
   assign rd_idx = pc_q[AW+1:2];
   assign wr_bad = (instruction_initialize_address[1:0] != 2'b00) ||
                   ((instruction_initialize_address >> (AW + 2)) != 32'd0);

   // A currently issued branch-to-self (beq rs,rs,-1) halts on the next unstalled edge.
   assign self_loop = instr_valid && (instr_out[31:26] == 6'b000100) &&
                      (instr_out[25:21] == instr_out[20:16]) && (instr_out[15:0] == 16'hFFFF);

   assign halted    = (state_q == S_HALT);
   assign fsm_state = state_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_LOAD;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD: if (!initialize) state_d = S_RUN;
         S_RUN: begin
            if (initialize)                                   state_d = S_LOAD;
            else if (!redirect_valid && !stall && self_loop)  state_d = S_HALT;
         end
         S_HALT: if (initialize) state_d = S_LOAD;
         default: state_d = S_LOAD;
      endcase
   end

   // Flow control: stall=1 means the consumer cannot take a word, so the issued word,
   // its PC and instr_valid hold; redirect_valid=1 overrides stall and inserts one bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q        <= '0;
         instr_out   <= '0;
         pc_out      <= '0;
         instr_valid <= 1'b0;
         init_error  <= 1'b0;
      end else begin
         if (initialize && wr_bad) init_error <= 1'b1;
         case (state_q)
            S_LOAD: begin
               pc_q        <= '0;
               instr_valid <= 1'b0;
            end
            S_RUN: begin
               if (initialize) begin
                  pc_q        <= '0;
                  instr_valid <= 1'b0;
               end else if (redirect_valid) begin
                  pc_q        <= redirect_target & ~32'd3;
                  instr_valid <= 1'b0;
               end else if (!stall) begin
                  if (self_loop) begin
                     instr_valid <= 1'b0;
                  end else begin
                     instr_out   <= mem[rd_idx];
                     pc_out      <= pc_q;
                     instr_valid <= 1'b1;
                     pc_q        <= pc_q + 32'd4;
                  end
               end
            end
            S_HALT: begin
               instr_valid <= 1'b0;
               if (initialize) pc_q <= '0;
            end
            default: begin
               pc_q        <= '0;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

   // Initialization writes are honoured in every state; reset clears the whole store.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      end else if (initialize && !wr_bad) begin
         mem[wr_idx] <= instruction_initialize_data;
      end
   end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 32-bit instruction words stored; it is a power of two, at most 2^30.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-low reset (0 = reset).
REQ-004 SHALL have port initialize, input, 1 bit: load mode; 1 = accept writes, fetch idle.
REQ-005 SHALL have port instruction_initialize_data, input, 32 bits: instruction word to store.
REQ-006 SHALL have port instruction_initialize_address, input, 32 bits: byte address of the word to store.
REQ-007 SHALL have port stall, input, 1 bit: consumer not ready; hold the fetch outputs.
REQ-008 SHALL have port redirect_valid, input, 1 bit: a jump or taken branch resolved downstream.
REQ-009 SHALL have port redirect_target, input, 32 bits: byte address to fetch from next.
REQ-010 SHALL have port instr_out, output, 32 bits: fetched instruction.
REQ-011 SHALL have port pc_out, output, 32 bits: byte address of instr_out.
REQ-012 SHALL have port instr_valid, output, 1 bit: instr_out and pc_out are valid this cycle.
REQ-013 SHALL have port halted, output, 1 bit: a self-loop branch has been issued.
REQ-014 SHALL have port init_error, output, 1 bit: sticky flag set by a rejected initialization write.

Function
REQ-015 SHALL implement a three-state FSM: LOAD, RUN, HALT.
REQ-016 In LOAD with initialize=1, each cycle SHALL write data to word index addr[log2(DEPTH_WORDS)+1:2].
REQ-017 A LOAD write SHALL be ignored, and init_error set, when addr[1:0]!=0 or addr>=4*DEPTH_WORDS.
REQ-018 LOAD->RUN SHALL occur on the first edge where initialize=0; the internal PC is 0 at entry.
REQ-019 initialize=1 in RUN or HALT SHALL force LOAD on the next edge: instr_valid=0, halted=0, PC=0; the write on that same edge is performed.
REQ-020 In RUN, with stall=0 and redirect_valid=0, each edge SHALL register instr_out=mem[PC index], pc_out=PC, instr_valid=1, then set PC=PC+4 (single-cycle latency, one word per cycle).
REQ-021 With stall=1 and redirect_valid=0, instr_out, pc_out, instr_valid and PC SHALL hold unchanged.
REQ-022 redirect_valid=1 SHALL take priority over stall: on that edge PC=redirect_target, instr_valid=0 (one bubble), and instr_out/pc_out are don't-care.
REQ-023 redirect_target with bits[1:0]!=0 SHALL be truncated to word alignment.
REQ-024 PC SHALL be 32 bits and wrap modulo 2^32; memory indexing SHALL use only the index bits, so fetch wraps modulo DEPTH_WORDS.
REQ-025 Self-loop detection: an issued word with opcode[31:26]=000100, rs==rt and imm[15:0]=0xFFFF SHALL move the FSM to HALT on the next unstalled edge.
REQ-026 In HALT, outputs SHALL be instr_valid=0, halted=1, PC frozen, and redirect and stall ignored; exit is only by reset or initialize=1.
REQ-027 A redirect on the same edge as the self-loop issue SHALL win: no HALT.
REQ-028 Memory SHALL be a synchronous-write array; reads are registered per REQ-020 and are never combinational to the outputs.

Reset
REQ-029 While rst=0, the following SHALL hold asynchronously: FSM=LOAD, PC=0, instr_out=0, pc_out=0, instr_valid=0, halted=0, init_error=0, and all memory words=0 (an unwritten word reads as NOP).
REQ-030 Release of rst SHALL take effect at the next clk edge; initialize is sampled from that edge onward.
REQ-031 Reset asserted mid-RUN or mid-HALT SHALL discard all fetch state and memory contents.

Verification
REQ-032 Load addresses 0/4/8 with 0x00020820, 0x00844022, 0x00A63825, then drop initialize -> instr_valid rises one edge later with pc_out=0, instr_out=0x00020820; the next two edges give pc_out 4 and 8.
REQ-033 Hold stall=1 for 3 cycles at pc_out=4 -> outputs are stable; release -> pc_out=8 on the next edge with no word skipped.
REQ-034 Assert redirect_valid with target 0x14 (stall=1 simultaneously) -> one bubble with instr_valid=0, then pc_out=0x14 with instr_out=mem[5].
REQ-035 Place 0x1000FFFF at 0x1C and run to it -> it is issued once with instr_valid=1, then halted=1 and instr_valid=0 persist; asserting initialize returns the FSM to LOAD with halted=0.
REQ-036 Write to address 0x102 and to address 0x100 (DEPTH_WORDS=64) -> init_error=1, memory is unchanged, and the flag stays set until rst=0.
REQ-037 Pulse rst=0 mid-RUN between clock edges -> outputs clear immediately; after release and initialize=0, fetch restarts at pc_out=0 and instr_out=0.
